// File: rtl/dragon_io_pkg.sv
// Shared constants and types for the dragon I/O slice.
// Counter widths live here so every block that uses them sizes its registers the same way.
package dragon_io_pkg;

   localparam int CNT_W          = 20;  // dwell counter width
   localparam int PEND_W         = 3;   // queued-edge counter width
   localparam int DEBOUNCE_CNT_W = 16;  // upstream debounce counter width

   // The four ways the queued-edge count can move in a single cycle.
   typedef enum logic [1:0] {
      PEND_KEEP,
      PEND_INC,
      PEND_DEC,
      PEND_DROP
   } pend_op_e;

endpackage

// File: rtl/dwell_driver_if.sv
// Level-in / level-out bundle of the dwell driver, together with its status outputs.
// The producer of din uses the master modport and the driver uses the slave modport.
interface dwell_driver_if import dragon_io_pkg::*; ();

   logic              din;
   logic              dout;
   logic              busy;
   logic [PEND_W-1:0] pending;
   logic              overflow;

   modport master (
      output din,
      input  dout, busy, pending, overflow
   );

   modport slave (
      input  din,
      output dout, busy, pending, overflow
   );

endinterface

// File: rtl/dwell_driver.sv
// Reproduces a clean input level on dout edge-for-edge, holding each output level for at least HOLD+1 clocks.
// Input edges that arrive during a dwell are queued, up to PEND_MAX of them, and replayed in order afterwards.
module dwell_driver
   import dragon_io_pkg::*;
#(
   parameter int HOLD     = 400000,
   parameter int PEND_MAX = 7
) (
   input  logic           clock,
   input  logic           reset,
   dwell_driver_if.slave  io
);

   localparam logic [CNT_W-1:0]  HOLD_C     = CNT_W'(HOLD);
   localparam logic [PEND_W-1:0] PEND_MAX_C = PEND_W'(PEND_MAX);

   logic              din_q;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [PEND_W-1:0] pending_q,  pending_d;
   logic              dout_q,     dout_d;
   logic              overflow_q, overflow_d;
   logic              busy_q,     busy_d;

   logic              din_edge;
   logic              at_hold;
   logic              toggle;
   pend_op_e          pend_op;

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      din_edge   = 1'b0;
      at_hold    = 1'b0;
      toggle     = 1'b0;
      pend_op    = PEND_KEEP;
      cnt_d      = cnt_q;
      pending_d  = pending_q;
      dout_d     = dout_q;
      overflow_d = overflow_q;
      busy_d     = 1'b0;

      din_edge = (io.din != din_q);
      at_hold  = (cnt_q == HOLD_C);
      // A toggle is allowed only on the registered pending count, never on an edge arriving in this same cycle.
      toggle   = at_hold && (pending_q != '0);

      if (din_edge && !toggle) begin
         pend_op = (pending_q < PEND_MAX_C) ? PEND_INC : PEND_DROP;
      end else if (toggle && !din_edge) begin
         pend_op = PEND_DEC;
      end

      unique case (pend_op)
         PEND_INC:  pending_d = pending_q + PEND_W'(1);
         PEND_DEC:  pending_d = pending_q - PEND_W'(1);
         PEND_DROP: overflow_d = 1'b1;
         default:   pending_d = pending_q;
      endcase

      if (toggle) begin
         dout_d = ~dout_q;
         cnt_d  = '0;
      end else if (cnt_q < HOLD_C) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      busy_d = (pending_d != '0) || (cnt_d != HOLD_C);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         // Come out of reset already aligned with din and with the dwell elapsed, so the first edge is served at once.
         din_q      <= io.din;
         dout_q     <= io.din;
         cnt_q      <= HOLD_C;
         pending_q  <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         din_q      <= io.din;
         dout_q     <= dout_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
      end
   end

   assign io.dout     = dout_q;
   assign io.busy     = busy_q;
   assign io.pending  = pending_q;
   assign io.overflow = overflow_q;

endmodule
